// File: rtl/llc_mem_responder.sv
// llc_mem_responder: direct-mapped line store answering LLC fill/writeback
// requests. Writes complete in one cycle; reads return after LATENCY cycles
// and block further requests until the response is consumed.
module llc_mem_responder #(
  parameter int LINE_BITS = 128,
  parameter int ADDR_BITS = 28,
  parameter int IDX_BITS  = 6,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 llc_mem_req_valid,
  output logic                 llc_mem_req_ready,
  input  logic                 llc_mem_req_hwrite,
  input  logic [ADDR_BITS-1:0] llc_mem_req_addr,
  input  logic [LINE_BITS-1:0] llc_mem_req_line,
  output logic                 llc_mem_rsp_valid,
  input  logic                 llc_mem_rsp_ready,
  output logic [LINE_BITS-1:0] llc_mem_rsp_line
);

  localparam int TAG_BITS = ADDR_BITS - IDX_BITS;
  localparam int ENTRIES  = 1 << IDX_BITS;
  // Counter preload; the WAIT state adds one cycle beyond the count.
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RSP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ENTRIES-1:0]    vld_q;
  logic [TAG_BITS-1:0]   tag_mem  [ENTRIES];
  logic [LINE_BITS-1:0]  line_mem [ENTRIES];
  logic [LINE_BITS-1:0]  rsp_q;

  logic [IDX_BITS-1:0]   idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  req_fire, wr_fire, rd_fire, rsp_fire, hit;
  logic [LINE_BITS-1:0]  rd_data;

  assign idx      = llc_mem_req_addr[IDX_BITS-1:0];
  assign tag      = llc_mem_req_addr[ADDR_BITS-1:IDX_BITS];
  assign llc_mem_req_ready = rst && (state_q == IDLE);
  assign req_fire = llc_mem_req_valid && llc_mem_req_ready;
  assign wr_fire  = req_fire && llc_mem_req_hwrite;
  assign rd_fire  = req_fire && !llc_mem_req_hwrite;
  assign rsp_fire = llc_mem_rsp_valid && llc_mem_rsp_ready;
  assign hit      = vld_q[idx] && (tag_mem[idx] == tag);
  assign rd_data  = hit ? line_mem[idx] : '0;

  assign llc_mem_rsp_valid = (state_q == RSP);
  assign llc_mem_rsp_line  = (state_q == RSP) ? rsp_q : '0;

  // State and latency counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter only moves while nonzero, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (rd_fire) begin
          if (LATENCY == 1) begin
            state_d = RSP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RSP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      RSP: begin
        if (rsp_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid bits are the only storage state that must reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         vld_q      <= '0;
    else if (wr_fire) vld_q[idx] <= 1'b1;
  end

  // Tag and line arrays, written on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      tag_mem[idx]  <= tag;
      line_mem[idx] <= llc_mem_req_line;
    end
  end

  // Read data snapshot taken on the accept edge and held through RSP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         rsp_q <= '0;
    else if (rd_fire) rsp_q <= rd_data;
  end

endmodule

// File: tb/tb_llc_mem_responder.sv
// Scoreboard bench: two responders (LATENCY 4 and 1) driven by directed
// requests; a per-instance monitor checks latency, data and stability.
module tb_llc_mem_responder;

  typedef struct {
    logic [127:0] line;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid  [2];
  logic         req_ready  [2];
  logic         req_hwrite [2];
  logic [27:0]  req_addr   [2];
  logic [127:0] req_line   [2];
  logic         rsp_valid  [2];
  logic         rsp_ready  [2];
  logic [127:0] rsp_line   [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    llc_mem_responder #(
      .LINE_BITS(128),
      .ADDR_BITS(28),
      .IDX_BITS (6),
      .LATENCY  ((g == 0) ? 4 : 1)
    ) u_dut (
      .clk               (clk),
      .rst               (rst),
      .llc_mem_req_valid (req_valid[g]),
      .llc_mem_req_ready (req_ready[g]),
      .llc_mem_req_hwrite(req_hwrite[g]),
      .llc_mem_req_addr  (req_addr[g]),
      .llc_mem_req_line  (req_line[g]),
      .llc_mem_rsp_valid (rsp_valid[g]),
      .llc_mem_rsp_ready (rsp_ready[g]),
      .llc_mem_rsp_line  (rsp_line[g])
    );
  end

  function automatic int q_size(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t q_front(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void q_pop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void q_push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Response monitor, one per instance.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int LAT = (g == 0) ? 4 : 1;
    logic held   = 1'b0;
    logic chk_rd = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
      if (!rst) begin
        held   = 1'b0;
        chk_rd = 1'b0;
      end else begin
        if (chk_rd) begin
          check($sformatf("req_ready_after_hs[%0d]", g), 128'(req_ready[g]), 128'd1);
          chk_rd = 1'b0;
        end
        if (rsp_valid[g]) begin
          if (!held) begin
            if (q_size(g) == 0) begin
              fail_now($sformatf("unexpected_rsp[%0d] line %h", g, rsp_line[g]));
            end else begin
              cur = q_front(g);
              // Valid first seen after edge accept+LATENCY-1.
              check($sformatf("rsp_latency[%0d]", g), 128'(cyc - cur.cyc), 128'(LAT - 1));
              check($sformatf("rsp_line[%0d]", g), rsp_line[g], cur.line);
            end
          end else begin
            check($sformatf("rsp_line_stable[%0d]", g), rsp_line[g], cur.line);
          end
          check($sformatf("req_ready_in_rsp[%0d]", g), 128'(req_ready[g]), 128'd0);
          if (rsp_ready[g]) begin
            if (q_size(g) > 0) q_pop(g);
            chk_rd = 1'b1;
          end
          held = !rsp_ready[g];
        end else begin
          check($sformatf("rsp_line_idle_zero[%0d]", g), rsp_line[g], 128'd0);
          held = 1'b0;
        end
      end
    end
  end

  // Issue one request; reads push their expected response.
  task automatic req(input int i, input logic wr, input logic [27:0] a,
                     input logic [127:0] d, input logic [127:0] exp, output int acc);
    exp_t e;
    @(negedge clk);
    req_valid[i]  = 1'b1;
    req_hwrite[i] = wr;
    req_addr[i]   = a;
    req_line[i]   = d;
    for (int n = 0; n < 100; n++) begin
      if (req_ready[i]) break;
      @(negedge clk);
    end
    if (!req_ready[i]) begin
      fail_now($sformatf("req_accept_timeout[%0d] addr %h", i, a));
      req_valid[i] = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid[i] = 1'b0;
    if (!wr) begin
      e.line = exp;
      e.cyc  = acc;
      q_push(i, e);
    end
  endtask

  task automatic drain(input int i);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (q_size(i) == 0 && !rsp_valid[i]) return;
    end
    fail_now($sformatf("drain_timeout[%0d]", i));
  endtask

  task automatic burst(input int i);
    int acc0, acc;
    for (int k = 0; k < 4; k++) begin
      req(i, 1'b1, 28'(k), {4{32'hC0DE_0000 + 32'(k)}}, '0, acc);
      if (k == 0) acc0 = acc;
      else check($sformatf("wr_back_to_back[%0d] k%0d", i, k), 128'(acc - acc0), 128'(k));
    end
    for (int k = 0; k < 4; k++)
      req(i, 1'b0, 28'(k), '0, {4{32'hC0DE_0000 + 32'(k)}}, acc);
    drain(i);
  endtask

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] LINE_45 = {4{32'h1234_5678}};

  initial begin
    int acc;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_hwrite[i] = 1'b0; req_addr[i] = '0;
      req_line[i]  = '0;   rsp_ready[i]  = 1'b1;
    end
    @(negedge clk);
    check("req_ready_in_reset", 128'(req_ready[0]), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_req_ready[%0d]", i), 128'(req_ready[i]), 128'd1);
      check($sformatf("reset_rsp_valid[%0d]", i), 128'(rsp_valid[i]), 128'd0);
    end

    // Write then read back; unwritten address reads zero.
    req(0, 1'b1, 28'h0000005, LINE_A5, '0, acc);
    req(0, 1'b0, 28'h0000005, '0, LINE_A5, acc);
    req(0, 1'b0, 28'h0000010, '0, '0, acc);
    drain(0);

    // Alias at index 5 with tag 1 evicts the earlier line.
    req(0, 1'b1, 28'h0000045, LINE_45, '0, acc);
    req(0, 1'b0, 28'h0000005, '0, '0, acc);
    req(0, 1'b0, 28'h0000045, '0, LINE_45, acc);
    drain(0);

    // Backpressure: hold the response for about 10 cycles.
    rsp_ready[0] = 1'b0;
    req(0, 1'b0, 28'h0000045, '0, LINE_45, acc);
    repeat (13) @(negedge clk);
    rsp_ready[0] = 1'b1;
    drain(0);

    burst(0);
    burst(1);

    // Reset while a read is in WAIT.
    req(0, 1'b0, 28'h0000045, '0, LINE_45, acc);
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    #1;
    check("rst_mid_wait_rsp_valid", 128'(rsp_valid[0]), 128'd0);
    check("rst_mid_wait_req_ready", 128'(req_ready[0]), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", 128'(req_ready[0]), 128'd1);
    repeat (8) @(negedge clk);
    req(0, 1'b0, 28'h0000045, '0, '0, acc);
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/llc_mem_responder.md
LLC_MEM_RESPONDER -- requirements
Module: llc_mem_responder

Interface
REQ-001 Parameter LINE_BITS, default 128, width of one cache line of data.
REQ-002 Parameter ADDR_BITS, default 28, width of the line address.
REQ-003 Parameter IDX_BITS, default 6, sets the number of storage entries (2**IDX_BITS).
REQ-004 Parameter LATENCY, default 4, read latency in cycles; legal range 1..15.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 llc_mem_req_valid  in  1  request present.
REQ-008 llc_mem_req_ready  out  1  responder can accept a request.
REQ-009 llc_mem_req_hwrite  in  1  1 = full-line write, 0 = line read.
REQ-010 llc_mem_req_addr  in  ADDR_BITS  line address.
REQ-011 llc_mem_req_line  in  LINE_BITS  write data; ignored on reads.
REQ-012 llc_mem_rsp_valid  out  1  read response present.
REQ-013 llc_mem_rsp_ready  in  1  consumer accepts the response.
REQ-014 llc_mem_rsp_line  out  LINE_BITS  read data.

Function
REQ-015 Storage SHALL hold 2**IDX_BITS entries; each entry is {valid, tag[ADDR_BITS-IDX_BITS], line}, indexed by addr[IDX_BITS-1:0] with tag = addr[ADDR_BITS-1:IDX_BITS].
REQ-016 The FSM SHALL have states IDLE, WAIT and RSP; llc_mem_req_ready = 1 only in IDLE.
REQ-017 Request handshake = valid & ready at a rising edge; inputs are sampled only on that edge.
REQ-018 Accepted write: on the same edge the entry SHALL be written (line, tag, valid=1); the FSM stays in IDLE and no response is produced.
REQ-019 Back-to-back writes SHALL be accepted every cycle with no bubbles.
REQ-020 Accepted read: on the same edge the responder SHALL snapshot the read data into a response register.
REQ-021 Read data is the entry line if valid=1 and the tag matches; otherwise it is all zeros.
REQ-022 Accepted read with LATENCY=1: next state is RSP.
REQ-023 Accepted read with LATENCY>1: next state is WAIT, with a 4-bit counter loaded to LATENCY-2.
REQ-024 WAIT: the counter decrements each cycle; when it is 0, next state is RSP.
REQ-025 Latency: a read accepted at edge E SHALL raise llc_mem_rsp_valid immediately after edge E+LATENCY-1, i.e. valid is visible LATENCY cycles after acceptance.
REQ-026 RSP: llc_mem_rsp_valid = 1, and llc_mem_rsp_line SHALL stay stable until a response handshake.
REQ-027 On the response handshake edge the FSM SHALL go to IDLE; llc_mem_req_ready rises in the following cycle, with no same-cycle accept.
REQ-028 Outside RSP, llc_mem_rsp_valid = 0 and llc_mem_rsp_line = 0.
REQ-029 At most one read SHALL be outstanding; reads are blocking, so a write can never overtake a pending read.
REQ-030 Index aliasing: a write to an address with the same index but a different tag SHALL overwrite the entry; a subsequent read of the old address then returns zeros.
REQ-031 llc_mem_req_valid without ready (WAIT/RSP) SHALL have no effect; the requester holds the request.
REQ-032 The counter SHALL never underflow; no other arithmetic is performed.

Reset
REQ-033 On rst low, the FSM SHALL go to IDLE and the counter to 0, asynchronously.
REQ-034 On rst low, all valid bits SHALL clear to 0.
REQ-035 On rst low, the response register and llc_mem_rsp_valid SHALL clear to 0.
REQ-036 On rst low, llc_mem_req_ready SHALL be 1 while rst is high and the FSM is in IDLE; tag and line storage need not be reset.
REQ-037 Reset during WAIT or RSP SHALL abandon the pending read with no response emitted; after release, the first read of any address returns zeros.

Verification
REQ-038 Write addr 0x0000005 line 0xA5..A5, then read 0x0000005 with LATENCY=4 -> rsp_valid exactly 4 cycles after read accept, line 0xA5..A5.
REQ-039 Read 0x0000010 after reset -> line all zeros, rsp_valid after LATENCY cycles.
REQ-040 Write 0x0000045 (index 5, tag 1) over 0x0000005, then read 0x0000005 -> zeros; read 0x0000045 -> written data.
REQ-041 Hold rsp_ready=0 for 10 cycles in RSP -> valid and line stable; req_ready=0 throughout; req_ready=1 the cycle after the handshake.
REQ-042 Four consecutive-cycle writes to indices 0..3, then reads -> all accepted at one per cycle, each read returns its data; repeat with LATENCY=1 -> valid the cycle after accept.
REQ-043 Assert rst mid-WAIT -> no rsp_valid; ready=1 after release; re-read of a written address returns zeros.
